// File: rtl/bd_access_seq.sv
// bd_access_seq: turns asynchronous ZX read/write cycles, already decoded to a
// target (W5300, SL811 or internal ports), into fclk-timed chip selects,
// strobes and bus buffer enables with setup / strobe / hold phases.
// One target is granted per Z80 cycle; a new cycle is accepted only after
// the previous one has fully ended.
module bd_access_seq #(
  parameter int CNTW      = 3,
  parameter int SETUP_CYC = 1,
  parameter int STB_W5300 = 3,
  parameter int STB_SL811 = 4,
  parameter int STB_PORTS = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic fclk,
  input  logic zrst_n,
  input  logic zrd_n,
  input  logic zwr_n,
  input  logic req_w5300,
  input  logic req_sl811,
  input  logic req_ports,
  output logic w5300_cs_n,
  output logic sl811_cs_n,
  output logic ports_wrstb_n,
  output logic brd_n,
  output logic bwr_n,
  output logic bd_oe,
  output logic zd_le,
  output logic zd_oe,
  output logic busy
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAITEND} state_e;
  typedef enum logic [1:0] {T_W5300, T_SL811, T_PORTS} tgt_e;

  localparam logic [CNTW-1:0] SETUP_LD = CNTW'(SETUP_CYC - 1);
  localparam logic [CNTW-1:0] HOLD_LD  = CNTW'(HOLD_CYC - 1);

  // Phase counter reload value for the strobe phase of each target.
  function automatic logic [CNTW-1:0] stb_ld(input tgt_e t);
    case (t)
      T_W5300: stb_ld = CNTW'(STB_W5300 - 1);
      T_SL811: stb_ld = CNTW'(STB_SL811 - 1);
      default: stb_ld = CNTW'(STB_PORTS - 1);
    endcase
  endfunction

  logic [1:0]      rd_sync_q, wr_sync_q;
  logic            rd_s, wr_s, act, any_req;
  state_e          state_q, state_d;
  tgt_e            tgt_q, tgt_d;
  logic            dir_wr_q, dir_wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            zd_oe_q;
  logic            cs_act, stb_act;

  // Two-flop synchronisers for the raw ZX strobes (active high after this).
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      rd_sync_q <= '0;
      wr_sync_q <= '0;
    end else begin
      rd_sync_q <= {rd_sync_q[0], ~zrd_n};
      wr_sync_q <= {wr_sync_q[0], ~zwr_n};
    end
  end

  assign rd_s    = rd_sync_q[1];
  assign wr_s    = wr_sync_q[1];
  assign act     = rd_s | wr_s;
  assign any_req = req_w5300 | req_sl811 | req_ports;

  // Sequencer state, captured target/direction and phase counter.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      state_q  <= S_IDLE;
      tgt_q    <= T_W5300;
      dir_wr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dir_wr_q <= dir_wr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: target and direction are frozen at start; a strobe that
  // disappears during SETUP/STROBE cuts straight to the hold phase.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dir_wr_d = dir_wr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (act && any_req) begin
          dir_wr_d = ~rd_s;
          tgt_d    = req_w5300 ? T_W5300 : (req_sl811 ? T_SL811 : T_PORTS);
          if (SETUP_CYC > 0) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_STROBE;
            cnt_d   = stb_ld(tgt_d);
          end
        end
      end
      S_SETUP: begin
        if (!act) begin
          state_d = (HOLD_CYC > 0) ? S_HOLD : S_WAITEND;
          cnt_d   = HOLD_LD;
        end else if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = stb_ld(tgt_q);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_STROBE: begin
        if (!act || cnt_q == '0) begin
          state_d = (HOLD_CYC > 0) ? S_HOLD : S_WAITEND;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_WAITEND;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      S_WAITEND: begin
        if (!act) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-data output enable: rises after the latch pulse, held until the
  // Z80 ends its cycle.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n)                                  zd_oe_q <= 1'b0;
    else if (zd_le)                               zd_oe_q <= 1'b1;
    else if (state_q == S_WAITEND && !act)        zd_oe_q <= 1'b0;
    else if (state_q == S_IDLE)                   zd_oe_q <= 1'b0;
  end

  assign cs_act  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign stb_act = (state_q == S_STROBE);

  assign w5300_cs_n    = ~(cs_act && tgt_q == T_W5300);
  assign sl811_cs_n    = ~(cs_act && tgt_q == T_SL811);
  assign brd_n         = ~(stb_act && tgt_q != T_PORTS && !dir_wr_q);
  assign bwr_n         = ~(stb_act && tgt_q != T_PORTS && dir_wr_q);
  assign ports_wrstb_n = ~(stb_act && tgt_q == T_PORTS && dir_wr_q);
  assign bd_oe         = cs_act && dir_wr_q;
  // Latch on the final strobe cycle of a read that was not aborted.
  assign zd_le         = stb_act && cnt_q == '0 && !dir_wr_q && act;
  assign zd_oe         = zd_oe_q;
  assign busy          = (state_q != S_IDLE);

endmodule
